serial_pattern_gen: RTL and testbench
=====================================

SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = shift MSB first and 0 = shift LSB first.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  request to accept data_in.
REQ-006 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port ready  output  1  high when a load is accepted this cycle.
REQ-008 SHALL have port serial_out  output  1  serial bit stream driving the downstream detector's serial input.
REQ-009 SHALL have port serial_valid  output  1  high while serial_out carries a data or parity bit.
REQ-010 SHALL have port done  output  1  one-cycle pulse on the final bit of a frame.

Function
REQ-011 SHALL implement states IDLE, SHIFT and, with the parity feature compiled in, PARITY.
REQ-012 SHALL drive ready = 1 only in IDLE.
REQ-013 SHALL, on an edge with load=1 in IDLE, capture data_in into the shift register, clear the bit counter and enter SHIFT.
REQ-014 SHALL drive all outputs from registers; the first data bit appears on serial_out in the cycle after the accepting edge (latency 1).
REQ-015 SHALL present one bit per cycle for exactly WIDTH cycles in SHIFT, with serial_valid=1 in each.
REQ-016 SHALL shift MSB first when MSB_FIRST=1 and LSB first when MSB_FIRST=0.
REQ-017 SHALL use a bit counter of $clog2(WIDTH) bits, counting 0..WIDTH-1 with no wrap past WIDTH-1.
REQ-018 SHALL, without parity, assert done with the last data bit, then return to IDLE on the next edge.
REQ-019 SHALL ignore load while not in IDLE, leaving the shift register and counter unchanged.
REQ-020 SHALL drive serial_out=0 and serial_valid=0 in IDLE.
REQ-021 SHALL hold IDLE for at least one cycle between frames; back-to-back frames are separated by exactly one idle cycle.

Reset
REQ-022 SHALL, on any edge with reset=1, set the state to IDLE, the shift register and counter to 0, serial_out=0, serial_valid=0 and done=0.
REQ-023 SHALL drive ready=1 in the first cycle after reset is released.
REQ-024 SHALL give reset priority over load; a load coincident with reset is dropped.
REQ-025 SHALL, on reset during SHIFT or PARITY, abort the frame; no done pulse is issued for it.

Configuration
REQ-026 SHALL compile the parity feature in when the macro SERIAL_PARITY_EN is defined: after the last data bit, enter PARITY for one cycle and output the even parity (XOR of the captured word) with serial_valid=1 and done=1.
REQ-027 SHALL, when SERIAL_PARITY_EN is defined, not assert done on the last data bit; the frame is WIDTH+1 bits long.
REQ-028 SHALL, when SERIAL_PARITY_EN is undefined, omit the PARITY state and parity logic entirely; the frame is WIDTH bits long.

Verification
REQ-029 SHALL cover MSB-first, WIDTH=8, no parity: load 8'b0011_0101 -> serial_out 0,0,1,1,0,1,0,1 in cycles 1..8 after accept; done only in cycle 8; ready=1 in cycle 9.
REQ-030 SHALL cover LSB-first (MSB_FIRST=0): load 8'b0011_0101 -> serial_out 1,0,1,0,1,1,0,0; serial_valid high for exactly 8 cycles.
REQ-031 SHALL cover busy load: load 8'hA5, then assert load with 8'hFF at bit 3 -> stream remains 1,0,1,0,0,1,0,1 and the second word is never sent.
REQ-032 SHALL cover reset mid-frame: reset=1 during bit 4 of 8'hF0 -> next cycle serial_out=0, serial_valid=0, done=0, ready=1; no done pulse for the aborted frame.
REQ-033 SHALL cover parity with SERIAL_PARITY_EN defined: 8'hB1 -> 9th bit 0; 8'h07 -> 9th bit 1; done only on the 9th bit.
REQ-034 SHALL cover back-to-back: load held high -> frames separated by exactly one idle cycle with serial_valid=0.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial word generator: one bit per cycle, MSB or LSB first.
// Latency: first bit on serial_out the cycle after the accepting edge; all outputs registered.
// Backpressure: load is only taken in IDLE (ready=1); load while busy is ignored.
// Optional even-parity trailer bit is compiled in with `define SERIAL_PARITY_EN.
module serial_pattern_gen #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             done
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             so_nxt, sv_nxt, done_nxt, ready_nxt;
`ifdef SERIAL_PARITY_EN
   logic             par_q, par_nxt;
`endif

   // State register; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: accept in IDLE, leave SHIFT after the last data bit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (load) state_nxt = SHIFT;
`ifdef SERIAL_PARITY_EN
         SHIFT: if (cnt == LAST) state_nxt = PARITY;
         PARITY: state_nxt = IDLE;
`else
         SHIFT: if (cnt == LAST) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values: outputs are registered, so each cycle
   // computes what the line must carry in the following cycle.
   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      so_nxt    = 1'b0;
      sv_nxt    = 1'b0;
      done_nxt  = 1'b0;
      ready_nxt = (state_nxt == IDLE);
`ifdef SERIAL_PARITY_EN
      par_nxt   = par_q;
`endif
      case (state)
         IDLE: begin
            if (load) begin
               shreg_nxt = data_in;
               cnt_nxt   = '0;
               so_nxt    = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
               sv_nxt    = 1'b1;
`ifdef SERIAL_PARITY_EN
               par_nxt   = ^data_in;
`endif
            end
         end
         SHIFT: begin
            if (cnt != LAST) begin
               // shreg's head bit is on the line now; expose the next one.
               cnt_nxt = cnt + 1'b1;
               sv_nxt  = 1'b1;
               if (MSB_FIRST != 0) begin
                  so_nxt    = shreg[WIDTH-2];
                  shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
               end else begin
                  so_nxt    = shreg[1];
                  shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
               end
`ifndef SERIAL_PARITY_EN
               done_nxt = (cnt == LAST - 1'b1);
`endif
            end else begin
`ifdef SERIAL_PARITY_EN
               // Trailer bit ends the frame instead of the last data bit.
               so_nxt   = par_q;
               sv_nxt   = 1'b1;
               done_nxt = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg        <= '0;
         cnt          <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         done         <= 1'b0;
         ready        <= 1'b1;
`ifdef SERIAL_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         shreg        <= shreg_nxt;
         cnt          <= cnt_nxt;
         serial_out   <= so_nxt;
         serial_valid <= sv_nxt;
         done         <= done_nxt;
         ready        <= ready_nxt;
`ifdef SERIAL_PARITY_EN
         par_q        <= par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: MSB-first and LSB-first instances share stimulus.
// Expected per-cycle outputs are queued when a word is driven and popped each cycle.
// An empty queue means the generator must be idle (ready=1, line quiet).
module tb_serial_pattern_gen;

   localparam int W = 8;
`ifdef SERIAL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FL = W + (PAR ? 1 : 0);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset   = 1'b1;
   logic         load    = 1'b0;
   logic [W-1:0] data_in = '0;

   logic m_ready, m_so, m_sv, m_done;
   logic l_ready, l_so, l_sv, l_done;

   serial_pattern_gen #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in),
      .ready(m_ready), .serial_out(m_so), .serial_valid(m_sv), .done(m_done));

   serial_pattern_gen #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .reset(reset), .load(load), .data_in(data_in),
      .ready(l_ready), .serial_out(l_so), .serial_valid(l_sv), .done(l_done));

   typedef struct packed {
      logic vld;
      logic sbit;
      logic dn;
      logic rdy;
   } exp_t;

   localparam exp_t IDLE_E = '{vld: 1'b0, sbit: 1'b0, dn: 1'b0, rdy: 1'b1};

   exp_t q_msb[$];
   exp_t q_lsb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] w);
      exp_t e;
      for (int k = 0; k < W; k++) begin
         e.vld  = 1'b1;
         e.rdy  = 1'b0;
         e.dn   = (k == W - 1) && !PAR;
         e.sbit = w[W-1-k];
         q_msb.push_back(e);
         e.sbit = w[k];
         q_lsb.push_back(e);
      end
      if (PAR) begin
         e.vld  = 1'b1;
         e.rdy  = 1'b0;
         e.dn   = 1'b1;
         e.sbit = ^w;
         q_msb.push_back(e);
         q_lsb.push_back(e);
      end
   endtask

   task automatic push_idle();
      q_msb.push_back(IDLE_E);
      q_lsb.push_back(IDLE_E);
   endtask

   // One clock: sample just after the edge and compare both instances.
   task automatic cycle();
      exp_t em, el;
      @(posedge clk);
      #1;
      em = (q_msb.size() != 0) ? q_msb.pop_front() : IDLE_E;
      el = (q_lsb.size() != 0) ? q_lsb.pop_front() : IDLE_E;
      check("msb.serial_out",   m_so,    em.sbit);
      check("msb.serial_valid", m_sv,    em.vld);
      check("msb.done",         m_done,  em.dn);
      check("msb.ready",        m_ready, em.rdy);
      check("lsb.serial_out",   l_so,    el.sbit);
      check("lsb.serial_valid", l_sv,    el.vld);
      check("lsb.done",         l_done,  el.dn);
      check("lsb.ready",        l_ready, el.rdy);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Drive a load for one edge; returns in the first cycle of the frame.
   task automatic send(input logic [W-1:0] w);
      load    = 1'b1;
      data_in = w;
      push_frame(w);
      cycle();
      load    = 1'b0;
   endtask

   task automatic full_frame(input logic [W-1:0] w);
      send(w);
      run(FL - 1);
      run(1);
   endtask

   initial begin
      // Reset, with a coincident load that must be dropped.
      reset   = 1'b1;
      load    = 1'b1;
      data_in = 8'hFF;
      cycle();
      cycle();
      reset = 1'b0;
      load  = 1'b0;
      cycle();

      // Basic ordering in both directions.
      full_frame(8'b0011_0101);

      // Load asserted mid-frame must not disturb the stream or queue a word.
      send(8'hA5);
      run(2);
      load    = 1'b1;
      data_in = 8'hFF;
      cycle();
      load    = 1'b0;
      run(FL - 4);
      run(2);

      // Reset during bit 4 aborts the frame with no done pulse.
      send(8'hF0);
      run(2);
      cycle();
      reset = 1'b1;
      q_msb.delete();
      q_lsb.delete();
      cycle();
      reset = 1'b0;
      run(W + 2);

      // Parity-sensitive words (trailer bit 0 and 1 when compiled in).
      full_frame(8'hB1);
      full_frame(8'h07);

      // Back-to-back with load held: exactly one idle cycle between frames.
      load    = 1'b1;
      data_in = 8'h3C;
      push_frame(8'h3C);
      push_idle();
      push_frame(8'hC3);
      cycle();
      data_in = 8'hC3;
      run(FL - 1);
      run(1);
      cycle();
      load = 1'b0;
      run(FL - 1);
      run(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
